ct_f_spsram_rmw_param: RTL and testbench



---
 rtl/ct_f_spsram_rmw_param.sv | 184 ++++++++++++++++++
 tb/tb_ct_f_spsram_rmw_param.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ct_f_spsram_rmw_param.sv
// ct_f_spsram_rmw_param
// Single-port SRAM wrapper with the legacy active-low macro pins (A, CEN, GWEN,
// per-bit WEN). The word is stored as SEG_WIDTH-wide RAM segments. Each segment
// has one write enable. A write whose mask splits a segment is done as a
// read-modify-write over two cycles, and BUSY is raised for that time.
// After any write, Q is driven by a bypass register.
// Optional feature: define CT_F_SPSRAM_RMW_INIT_EN to zero-fill the whole RAM
// after reset. BUSY is high while the fill runs.
module ct_f_spsram_rmw_param #(
    parameter int DATA_WIDTH = 59,
    parameter int ADDR_WIDTH = 11,
    parameter int SEG_WIDTH  = 29
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic                  CEN,
    input  logic                  GWEN,
    input  logic [DATA_WIDTH-1:0] WEN,
    input  logic [DATA_WIDTH-1:0] D,
    output logic [DATA_WIDTH-1:0] Q,
    output logic                  BUSY
);

    localparam int NSEG  = (DATA_WIDTH + SEG_WIDTH - 1) / SEG_WIDTH;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RMW_WR = 2'd1,
        ST_INIT   = 2'd2
    } state_t;

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] addr_hold_reg, addr_hold_next;
    logic [DATA_WIDTH-1:0] d_lat_reg, d_lat_next;
    logic [DATA_WIDTH-1:0] wen_lat_reg, wen_lat_next;
    logic                  byp_valid_reg, byp_valid_next;
    logic [DATA_WIDTH-1:0] byp_sel_reg, byp_sel_next;
    logic [DATA_WIDTH-1:0] byp_data_reg, byp_data_next;
`ifdef CT_F_SPSRAM_RMW_INIT_EN
    logic [ADDR_WIDTH-1:0] init_cnt_reg, init_cnt_next;
`endif

    logic                  accept;
    logic                  any_partial;
    logic [NSEG-1:0]       seg_full;
    logic [NSEG-1:0]       seg_partial;
    logic [NSEG-1:0]       seg_lat_keep;
    logic [NSEG-1:0]       seg_we;
    logic [DATA_WIDTH-1:0] full_mask;
    logic [DATA_WIDTH-1:0] rdata;
    logic [DATA_WIDTH-1:0] merged;
    logic [DATA_WIDTH-1:0] wdata;
    logic [ADDR_WIDTH-1:0] ram_addr;

    // A new access is taken only when the wrapper is idle.
    assign BUSY        = (state_reg != ST_IDLE);
    assign accept      = !CEN && !BUSY;
    assign any_partial = |seg_partial;
    assign merged      = (rdata & wen_lat_reg) | (d_lat_reg & ~wen_lat_reg);

    // Segment RAMs. The top segment takes whatever bits remain.
    // The read is registered and read-first.
    generate
        for (genvar gi = 0; gi < NSEG; gi++) begin : g_seg
            localparam int LO = gi * SEG_WIDTH;
            localparam int W  = ((DATA_WIDTH - LO) < SEG_WIDTH) ? (DATA_WIDTH - LO) : SEG_WIDTH;

            logic [W-1:0] mem [DEPTH];
            logic [W-1:0] rdata_reg;

            assign seg_full[gi]     = (WEN[LO +: W] == '0);
            assign seg_partial[gi]  = !seg_full[gi] && !(&WEN[LO +: W]);
            assign seg_lat_keep[gi] = &wen_lat_reg[LO +: W];
            assign full_mask[LO +: W] = {W{seg_full[gi]}};
            assign rdata[LO +: W]   = rdata_reg;

            // One shared address drives both ports. The old word is captured
            // on the same edge as a write.
            always_ff @(posedge CLK) begin
                if (seg_we[gi]) begin
                    mem[ram_addr] <= wdata[LO +: W];
                end
                rdata_reg <= mem[ram_addr];
            end
        end
    endgenerate

    // Q shows the RAM word, with the bypass register laid over it after a write.
    assign Q = byp_valid_reg ? ((rdata & ~byp_sel_reg) | (byp_data_reg & byp_sel_reg)) : rdata;

    // Next-state logic, RAM port control and capture of the bypass and latch registers.
    always_comb begin
        state_next     = state_reg;
        addr_hold_next = addr_hold_reg;
        d_lat_next     = d_lat_reg;
        wen_lat_next   = wen_lat_reg;
        byp_valid_next = byp_valid_reg;
        byp_sel_next   = byp_sel_reg;
        byp_data_next  = byp_data_reg;
        ram_addr       = addr_hold_reg;
        wdata          = D;
        seg_we         = '0;
`ifdef CT_F_SPSRAM_RMW_INIT_EN
        init_cnt_next  = init_cnt_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    ram_addr       = A;
                    addr_hold_next = A;
                    byp_valid_next = 1'b0;
                    if (!GWEN) begin
                        if (any_partial) begin
                            // The old word is read on this edge and merged on the next one.
                            state_next   = ST_RMW_WR;
                            d_lat_next   = D;
                            wen_lat_next = WEN;
                        end else begin
                            seg_we         = seg_full;
                            byp_valid_next = 1'b1;
                            byp_sel_next   = full_mask;
                            byp_data_next  = D;
                        end
                    end
                end
            end
            ST_RMW_WR: begin
                wdata          = merged;
                seg_we         = ~seg_lat_keep;
                byp_valid_next = 1'b1;
                byp_sel_next   = '1;
                byp_data_next  = merged;
                state_next     = ST_IDLE;
            end
`ifdef CT_F_SPSRAM_RMW_INIT_EN
            ST_INIT: begin
                ram_addr      = init_cnt_reg;
                wdata         = '0;
                seg_we        = '1;
                init_cnt_next = init_cnt_reg + 1'b1;
                if (init_cnt_reg == '1) begin
                    state_next = ST_IDLE;
                end
            end
`endif
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset is asynchronous. An RMW cut short
    // by reset never reaches its write.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
`ifdef CT_F_SPSRAM_RMW_INIT_EN
            state_reg    <= ST_INIT;
            init_cnt_reg <= '0;
`else
            state_reg    <= ST_IDLE;
`endif
            addr_hold_reg <= '0;
            d_lat_reg     <= '0;
            wen_lat_reg   <= '0;
            byp_valid_reg <= 1'b0;
            byp_sel_reg   <= '0;
            byp_data_reg  <= '0;
        end else begin
`ifdef CT_F_SPSRAM_RMW_INIT_EN
            init_cnt_reg <= init_cnt_next;
`endif
            state_reg     <= state_next;
            addr_hold_reg <= addr_hold_next;
            d_lat_reg     <= d_lat_next;
            wen_lat_reg   <= wen_lat_next;
            byp_valid_reg <= byp_valid_next;
            byp_sel_reg   <= byp_sel_next;
            byp_data_reg  <= byp_data_next;
        end
    end

endmodule

// File: tb/tb_ct_f_spsram_rmw_param.sv
// Self-checking bench for ct_f_spsram_rmw_param.
// A bit-level reference memory predicts each Q value and pushes it to a
// scoreboard queue. The value is popped and compared when the DUT's result is due.
module tb_ct_f_spsram_rmw_param;

`ifdef CT_F_SPSRAM_RMW_INIT_EN
    localparam int AW = 4;
`else
    localparam int AW = 11;
`endif
    localparam int DW    = 59;
    localparam int SW    = 29;
    localparam int NS    = (DW + SW - 1) / SW;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] a = '0;
    logic          cen = 1'b1;
    logic          gwen = 1'b1;
    logic [DW-1:0] wen = '1;
    logic [DW-1:0] d = '0;
    logic [DW-1:0] q;
    logic          busy;

    logic [DW-1:0] model_mem [DEPTH];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] e;
    logic [DW-1:0] ones = '1;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    ct_f_spsram_rmw_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SEG_WIDTH(SW)) dut (
        .CLK(clk), .RST(rst), .A(a), .CEN(cen), .GWEN(gwen),
        .WEN(wen), .D(d), .Q(q), .BUSY(busy)
    );

    // True when any segment of the mask has both enabled and disabled bits.
    function automatic bit needs_rmw(input logic [DW-1:0] w);
        bit r;
        bit all0;
        bit all1;
        int hi;
        r = 1'b0;
        for (int s = 0; s < NS; s++) begin
            all0 = 1'b1;
            all1 = 1'b1;
            hi = (s * SW + SW - 1 < DW - 1) ? s * SW + SW - 1 : DW - 1;
            for (int b = s * SW; b <= hi; b++) begin
                if (w[b]) all0 = 1'b0;
                else      all1 = 1'b0;
            end
            if (!all0 && !all1) r = 1'b1;
        end
        return r;
    endfunction

    // Drives one access for one edge and pushes the Q value the model predicts.
    task automatic drive(input logic [AW-1:0] ta, input logic tg,
                         input logic [DW-1:0] tw, input logic [DW-1:0] td);
        @(negedge clk);
        a = ta; cen = 1'b0; gwen = tg; wen = tw; d = td;
        if (!tg) model_mem[ta] = (model_mem[ta] & tw) | (td & ~tw);
        exp_q.push_back(model_mem[ta]);
        @(posedge clk);
        #1;
        cen = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

`ifdef CT_F_SPSRAM_RMW_INIT_EN
    task automatic test_init();
        int cnt;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        while (busy && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        checks++;
        if (cnt != DEPTH) begin
            errors++;
            $display("FAIL init_busy_len: got %0d cycles, expected %0d", cnt, DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) begin
            drive(AW'(i), 1'b1, '1, '0);
            e = exp_q.pop_front();
            checks++;
            if (q !== e) begin
                errors++;
                $display("FAIL init_read[%0d]: Q=%h expected %h", i, q, e);
            end
        end
    endtask
`else
    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: BUSY=%b expected 0", busy); end
        @(negedge clk);
        rst = 1'b0;
        idle(1);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: BUSY=%b expected 0", busy); end
    endtask

    task automatic test_direct_write();
        drive(11'h005, 1'b0, '0, ones);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL dw_busy: BUSY=%b expected 0", busy); end
        e = exp_q.pop_front();
        checks++;
        if (q !== e) begin errors++; $display("FAIL dw_q_after_write: Q=%h expected %h", q, e); end
        drive(11'h005, 1'b1, '1, '0);
        e = exp_q.pop_front();
        checks++;
        if (q !== e || busy !== 1'b0) begin errors++; $display("FAIL dw_read: Q=%h BUSY=%b expected %h 0", q, busy, e); end
        idle(2);
        checks++;
        if (q !== ones) begin errors++; $display("FAIL dw_hold: Q=%h expected %h", q, ones); end
    endtask

    task automatic test_partial_rmw();
        drive(11'h010, 1'b0, '0, '0);
        e = exp_q.pop_front();
        checks++;
        if (q !== e) begin errors++; $display("FAIL rmw_preload: Q=%h expected %h", q, e); end
        drive(11'h010, 1'b0, ~59'h0F0, ones);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL rmw_busy_high: BUSY=%b expected 1", busy); end
        idle(1);
        e = exp_q.pop_front();
        checks++;
        if (busy !== 1'b0 || q !== e || q !== 59'h0F0) begin
            errors++;
            $display("FAIL rmw_result: Q=%h BUSY=%b expected %h 0", q, busy, e);
        end
        drive(11'h010, 1'b1, '1, '0);
        e = exp_q.pop_front();
        checks++;
        if (q !== e) begin errors++; $display("FAIL rmw_readback: Q=%h expected %h", q, e); end
    endtask

    task automatic test_mixed();
        logic [DW-1:0] v;
        logic [DW-1:0] w;
        logic [DW-1:0] ref_v;
        v = 59'h555555555555555;
        w = '1;
        w[28:0] = '0;
        w[30] = 1'b0;
        ref_v = v;
        ref_v[28:0] = '0;
        ref_v[30] = 1'b0;
        drive(11'h7FF, 1'b0, '0, v);
        e = exp_q.pop_front();
        checks++;
        if (q !== e) begin errors++; $display("FAIL mixed_preload: Q=%h expected %h", q, e); end
        drive(11'h7FF, 1'b0, w, '0);
        checks++;
        if (busy !== needs_rmw(w)) begin errors++; $display("FAIL mixed_busy: BUSY=%b expected %b", busy, needs_rmw(w)); end
        idle(1);
        e = exp_q.pop_front();
        checks++;
        if (q !== e || q !== ref_v) begin errors++; $display("FAIL mixed_result: Q=%h expected %h", q, e); end
        drive(11'h7FF, 1'b1, '1, '0);
        e = exp_q.pop_front();
        checks++;
        if (q !== e || q[58] !== 1'b1) begin errors++; $display("FAIL mixed_readback: Q=%h expected %h", q, e); end
    endtask

    task automatic test_dropped();
        drive(11'h020, 1'b0, '0, 59'h123);
        e = exp_q.pop_front();
        drive(11'h030, 1'b0, '0, '0);
        e = exp_q.pop_front();
        drive(11'h030, 1'b0, ~59'hF00, ones);
        // Read of another address in the busy cycle: it must be dropped.
        @(negedge clk);
        a = 11'h020; cen = 1'b0; gwen = 1'b1;
        @(posedge clk);
        #1;
        cen = 1'b1;
        e = exp_q.pop_front();
        checks++;
        if (busy !== 1'b0 || q !== e) begin errors++; $display("FAIL drop_read_result: Q=%h BUSY=%b expected %h 0", q, busy, e); end
        idle(2);
        checks++;
        if (q !== e) begin errors++; $display("FAIL drop_hold: Q=%h expected %h", q, e); end
        // Write to another address in the busy cycle: no RAM write.
        drive(11'h030, 1'b0, ~59'h00F, ones);
        @(negedge clk);
        a = 11'h020; cen = 1'b0; gwen = 1'b0; wen = '0; d = ones;
        @(posedge clk);
        #1;
        cen = 1'b1;
        e = exp_q.pop_front();
        checks++;
        if (q !== e) begin errors++; $display("FAIL drop_write_rmw: Q=%h expected %h", q, e); end
        drive(11'h020, 1'b1, '1, '0);
        e = exp_q.pop_front();
        checks++;
        if (q !== e) begin errors++; $display("FAIL drop_write_target: Q=%h expected %h", q, e); end
    endtask

    task automatic test_reset_mid_rmw();
        logic [DW-1:0] old_v;
        drive(11'h040, 1'b0, '0, 59'hABC);
        e = exp_q.pop_front();
        old_v = model_mem[11'h040];
        drive(11'h040, 1'b0, ~59'h00F, ones);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: BUSY=%b expected 0", busy); end
        // The aborted write leaves memory as it was.
        void'(exp_q.pop_back());
        model_mem[11'h040] = old_v;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(11'h040, 1'b1, '1, '0);
        e = exp_q.pop_front();
        checks++;
        if (q !== e || q !== 59'hABC) begin errors++; $display("FAIL midrst_readback: Q=%h expected %h", q, e); end
    endtask

    task automatic test_reset_q();
        drive(11'h000, 1'b0, '0, 59'h1234_5678);
        e = exp_q.pop_front();
        drive(11'h005, 1'b1, '1, '0);
        e = exp_q.pop_front();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (q !== model_mem[0] || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_q_addr0: Q=%h BUSY=%b expected %h 0", q, busy, model_mem[0]);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] w;
        w = '0;
        w[57:29] = '1;
        drive(11'h050, 1'b0, '0, ones);
        e = exp_q.pop_front();
        checks++;
        if (q !== e) begin errors++; $display("FAIL b2b_w1: Q=%h expected %h", q, e); end
        drive(11'h050, 1'b1, '1, '0);
        e = exp_q.pop_front();
        checks++;
        if (q !== e) begin errors++; $display("FAIL b2b_r1: Q=%h expected %h", q, e); end
        drive(11'h050, 1'b0, w, '0);
        e = exp_q.pop_front();
        checks++;
        if (q !== e || busy !== 1'b0) begin errors++; $display("FAIL b2b_w2: Q=%h BUSY=%b expected %h 0", q, busy, e); end
        drive(11'h051, 1'b0, '0, 59'h77);
        e = exp_q.pop_front();
        checks++;
        if (q !== e) begin errors++; $display("FAIL b2b_w3: Q=%h expected %h", q, e); end
        drive(11'h050, 1'b1, '1, '0);
        e = exp_q.pop_front();
        checks++;
        if (q !== e) begin errors++; $display("FAIL b2b_r2: Q=%h expected %h", q, e); end
    endtask
`endif

    initial begin
`ifdef CT_F_SPSRAM_RMW_INIT_EN
        test_init();
`else
        test_reset();
        test_direct_write();
        test_partial_rmw();
        test_mixed();
        test_dropped();
        test_reset_mid_rmw();
        test_reset_q();
        test_back_to_back();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
